ram_sp_clear: RTL and testbench

//  Parametrised single-port synchronous RAM with per-byte write enables, selectable

---
 rtl/ram_sp_clear.sv | 102 ++++++++++
 tb/tb_ram_sp_clear.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_clear.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write, and a post-reset clear sequencer.
// Read latency 1 clk; accesses are ignored (no backpressure, just dropped) until ready rises after DEPTH clear writes.
module ram_sp_clear #(
  parameter int                      DATA_WIDTH  = 16,
  parameter int                      ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0,
  parameter int                      READ_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [DATA_WIDTH/8-1:0]   byte_enable,
  input  logic                      write_enable,
  input  logic                      read_enable,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      data_valid,
  output logic                      ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clear_addr, clear_addr_nxt;

  logic                    user_wr, user_rd, clearing;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;
  logic [DATA_WIDTH-1:0]   rd_old, rd_new, rd_word;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clear_addr <= '0;
    end else begin
      state      <= state_nxt;
      clear_addr <= clear_addr_nxt;
    end
  end

  // The address saturates at the last word so the sweep never wraps or repeats.
  always_comb begin
    state_nxt      = state;
    clear_addr_nxt = clear_addr;
    case (state)
      CLEAR: begin
        if (&clear_addr) state_nxt = RUN;
        else             clear_addr_nxt = clear_addr + 1'b1;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready    = (state == RUN);
  assign clearing = (state == CLEAR);
  assign user_wr  = ready && write_enable;
  assign user_rd  = ready && read_enable;

  // Clear and user writes share a single write port so the array maps to block RAM.
  assign wr_en   = clearing || user_wr;
  assign wr_addr = clearing ? clear_addr : address;
  assign wr_data = clearing ? CLEAR_VALUE : data_in;
  assign wr_be   = clearing ? {NB{1'b1}} : byte_enable;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_old = mem[address];

  always_comb begin
    rd_new = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (write_enable && byte_enable[i]) rd_new[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign rd_word = (READ_MODE == 1) ? rd_new : rd_old;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= user_rd;
      if (user_rd) data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_ram_sp_clear.sv
// Scoreboard bench: two default-size RAMs (old-data / new-data read mode) share stimulus; a small RAM checks CLEAR_VALUE.
module tb_ram_sp_clear;

  logic        clk;
  logic        rst, rst_c;
  logic [9:0]  address;
  logic [15:0] data_in;
  logic [1:0]  be;
  logic        we, re;
  logic [15:0] a_dout, b_dout;
  logic        a_vld, b_vld, a_rdy, b_rdy;

  logic [3:0]  c_address;
  logic [15:0] c_data_in;
  logic [1:0]  c_be;
  logic        c_we, c_re;
  logic [15:0] c_dout;
  logic        c_vld, c_rdy;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] qc[$];

  int checks = 0;
  int errors = 0;

  ram_sp_clear #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CLEAR_VALUE(16'h0000), .READ_MODE(0)) dut_a (
    .clk(clk), .reset(rst), .address(address), .data_in(data_in), .byte_enable(be),
    .write_enable(we), .read_enable(re), .data_out(a_dout), .data_valid(a_vld), .ready(a_rdy));

  ram_sp_clear #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CLEAR_VALUE(16'h0000), .READ_MODE(1)) dut_b (
    .clk(clk), .reset(rst), .address(address), .data_in(data_in), .byte_enable(be),
    .write_enable(we), .read_enable(re), .data_out(b_dout), .data_valid(b_vld), .ready(b_rdy));

  ram_sp_clear #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_VALUE(16'hDEAD), .READ_MODE(0)) dut_c (
    .clk(clk), .reset(rst_c), .address(c_address), .data_in(c_data_in), .byte_enable(c_be),
    .write_enable(c_we), .read_enable(c_re), .data_out(c_dout), .data_valid(c_vld), .ready(c_rdy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every data_valid cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_vld) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
      else                chk("a_read_data", {16'h0, a_dout}, {16'h0, qa.pop_front()});
    end
    if (b_vld) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
      else                chk("b_read_data", {16'h0, b_dout}, {16'h0, qb.pop_front()});
    end
    if (c_vld) begin
      if (qc.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
      else                chk("c_read_data", {16'h0, c_dout}, {16'h0, qc.pop_front()});
    end
  end

  // Called at posedge+1; drives one access for exactly one clock.
  task automatic op(input logic w, input logic r, input logic [9:0] a, input logic [15:0] d,
                    input logic [1:0] b, input logic [15:0] ea, input logic [15:0] eb);
    we = w; re = r; address = a; data_in = d; be = b;
    if (r) begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic opc(input logic w, input logic r, input logic [3:0] a, input logic [15:0] d,
                     input logic [1:0] b, input logic [15:0] e);
    c_we = w; c_re = r; c_address = a; c_data_in = d; c_be = b;
    if (r) qc.push_back(e);
    @(posedge clk); #1;
    c_we = 1'b0; c_re = 1'b0;
  endtask

  // Release reset between edges and walk the full clear, poking an access mid-sweep.
  task automatic run_clear();
    rst = 1'b0;
    for (int e = 1; e <= 1024; e++) begin
      @(posedge clk); #1;
      if (e == 100) begin
        we = 1'b1; re = 1'b1; address = 10'd9; data_in = 16'hFFFF; be = 2'b11;
      end
      if (e == 101) begin
        we = 1'b0; re = 1'b0;
      end
      if (e == 102) begin
        chk("clear_ignore_vld_a", {31'h0, a_vld}, 32'd0);
        chk("clear_ignore_vld_b", {31'h0, b_vld}, 32'd0);
      end
      if (e == 1 || e == 1023) begin
        chk("ready_low_a", {31'h0, a_rdy}, 32'd0);
        chk("ready_low_b", {31'h0, b_rdy}, 32'd0);
      end
      if (e == 1024) begin
        chk("ready_high_a", {31'h0, a_rdy}, 32'd1);
        chk("ready_high_b", {31'h0, b_rdy}, 32'd1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst_c = 1'b1;
    we = 1'b0; re = 1'b0; address = '0; data_in = '0; be = '0;
    c_we = 1'b0; c_re = 1'b0; c_address = '0; c_data_in = '0; c_be = '0;
    #2;
    chk("reset_ready_a", {31'h0, a_rdy}, 32'd0);
    chk("reset_valid_a", {31'h0, a_vld}, 32'd0);
    chk("reset_dout_a",  {16'h0, a_dout}, 32'd0);
    chk("reset_dout_b",  {16'h0, b_dout}, 32'd0);
    run_clear();

    // Cleared contents, including the word poked during the clear
    op(0, 1, 10'd0,    16'h0, 2'b00, 16'h0000, 16'h0000);
    op(0, 1, 10'd5,    16'h0, 2'b00, 16'h0000, 16'h0000);
    op(0, 1, 10'd1023, 16'h0, 2'b00, 16'h0000, 16'h0000);
    op(0, 1, 10'd9,    16'h0, 2'b00, 16'h0000, 16'h0000);

    // Full and partial byte writes
    op(1, 0, 10'd3, 16'hABCD, 2'b11, 16'h0, 16'h0);
    op(0, 1, 10'd3, 16'h0,    2'b00, 16'hABCD, 16'hABCD);
    op(0, 0, 10'd0, 16'h0,    2'b00, 16'h0, 16'h0);
    op(1, 0, 10'd3, 16'h1234, 2'b01, 16'h0, 16'h0);
    op(0, 1, 10'd3, 16'h0,    2'b00, 16'hAB34, 16'hAB34);
    op(1, 0, 10'd3, 16'h5600, 2'b10, 16'h0, 16'h0);
    op(0, 1, 10'd3, 16'h0,    2'b00, 16'h5634, 16'h5634);
    op(1, 0, 10'd3, 16'hFFFF, 2'b00, 16'h0, 16'h0);
    op(0, 1, 10'd3, 16'h0,    2'b00, 16'h5634, 16'h5634);

    // Read-during-write: old vs merged new data
    op(1, 0, 10'd7, 16'h1111, 2'b11, 16'h0, 16'h0);
    op(1, 1, 10'd7, 16'h2222, 2'b11, 16'h1111, 16'h2222);
    op(0, 1, 10'd7, 16'h0,    2'b00, 16'h2222, 16'h2222);
    op(1, 1, 10'd7, 16'h3344, 2'b01, 16'h2222, 16'h2244);
    op(0, 1, 10'd7, 16'h0,    2'b00, 16'h2244, 16'h2244);

    // Reset from RUN and mid-clear restart
    op(1, 0, 10'd1023, 16'h5555, 2'b11, 16'h0, 16'h0);
    op(0, 1, 10'd1023, 16'h0,    2'b00, 16'h5555, 16'h5555);
    op(0, 0, 10'd0,    16'h0,    2'b00, 16'h0, 16'h0);
    rst = 1'b1; #1;
    chk("reset_run_ready_a", {31'h0, a_rdy}, 32'd0);
    chk("reset_run_ready_b", {31'h0, b_rdy}, 32'd0);
    rst = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    chk("reset_mid_clear_ready_a", {31'h0, a_rdy}, 32'd0);
    chk("reset_mid_clear_dout_a", {16'h0, a_dout}, 32'd0);
    run_clear();
    op(0, 1, 10'd1023, 16'h0, 2'b00, 16'h0000, 16'h0000);
    op(0, 1, 10'd3,    16'h0, 2'b00, 16'h0000, 16'h0000);
    op(0, 1, 10'd7,    16'h0, 2'b00, 16'h0000, 16'h0000);

    // Small RAM with a non-zero clear value
    rst_c = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      if (e == 15) chk("c_ready_low",  {31'h0, c_rdy}, 32'd0);
      if (e == 16) chk("c_ready_high", {31'h0, c_rdy}, 32'd1);
    end
    opc(0, 1, 4'd0,  16'h0, 2'b00, 16'hDEAD);
    opc(0, 1, 4'd7,  16'h0, 2'b00, 16'hDEAD);
    opc(0, 1, 4'd15, 16'h0, 2'b00, 16'hDEAD);
    opc(1, 0, 4'd4,  16'h0102, 2'b10, 16'h0);
    opc(0, 1, 4'd4,  16'h0, 2'b00, 16'h01AD);

    repeat (3) @(posedge clk);
    #1;
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    chk("qc_drained", qc.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
